// File: rtl/decoder256_ctrl.sv
// decoder256_ctrl: loads a parallel pattern into the serial decoder MSB-first, then
// streams signal bits and only reports decoder matches once a full N-bit window of
// valid signal is resident in the decoder.
module decoder256_ctrl #(
  parameter int unsigned N    = 256,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [N-1:0]    cfg_pattern,
  input  logic            sig_in,
  input  logic            sig_valid,
  output logic            dec_clr,
  output logic            dec_enable,
  output logic            dec_prgm,
  output logic            dec_sig,
  input  logic            dec_out,
  output logic            match,
  output logic [CNTW-1:0] match_count,
  output logic            armed,
  output logic            underrun
);

  localparam int unsigned LW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] PRIME = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [2:0]      state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [LW-1:0]   load_cnt_q, load_cnt_d;
  logic [CW-1:0]   prime_cnt_q, prime_cnt_d;
  logic [CNTW-1:0] count_d;
  logic            underrun_d, match_d, sig_d, prgm_d;
  logic            hs;

  // cfg_ready is a registered copy of "next state accepts a pattern", so it is
  // exactly the accept condition for the current state.
  assign hs = cfg_valid & cfg_ready;

  // Next-state, shift-register and counter logic
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    load_cnt_d  = load_cnt_q;
    prime_cnt_d = prime_cnt_q;
    count_d     = match_count;
    underrun_d  = underrun;
    match_d     = 1'b0;
    sig_d       = 1'b0;
    prgm_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d    = CLEAR;
          shreg_d    = cfg_pattern;
          count_d    = '0;
          underrun_d = 1'b0;
        end
      end
      CLEAR: begin
        // Present pattern MSB on the first load cycle.
        state_d    = LOAD;
        load_cnt_d = '0;
        prgm_d     = shreg_q[N-1];
        shreg_d    = {shreg_q[N-2:0], 1'b0};
      end
      LOAD: begin
        if (load_cnt_q == LW'(N - 1)) begin
          state_d     = PRIME;
          prime_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + LW'(1);
          prgm_d     = shreg_q[N-1];
          shreg_d    = {shreg_q[N-2:0], 1'b0};
        end
      end
      PRIME, RUN: begin
        if (hs) begin
          // Reprogram wins over any underrun in the same cycle.
          state_d    = CLEAR;
          shreg_d    = cfg_pattern;
          count_d    = '0;
          underrun_d = 1'b0;
        end else begin
          // An invalid cycle still shifts a 0 into the decoder.
          sig_d = sig_in & sig_valid;
          if (!sig_valid) begin
            state_d     = PRIME;
            prime_cnt_d = '0;
            underrun_d  = 1'b1;
          end else if (state_q == PRIME) begin
            if (prime_cnt_q == CW'(N - 1)) begin
              state_d     = RUN;
              prime_cnt_d = '0;
            end else begin
              prime_cnt_d = prime_cnt_q + CW'(1);
            end
          end else begin
            match_d = dec_out & armed;
            if (match_d && (match_count != CNT_MAX)) begin
              count_d = match_count + CNTW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      load_cnt_q  <= '0;
      prime_cnt_q <= '0;
      cfg_ready   <= 1'b0;
      dec_clr     <= 1'b1;
      dec_enable  <= 1'b0;
      dec_prgm    <= 1'b0;
      dec_sig     <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      armed       <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      load_cnt_q  <= load_cnt_d;
      prime_cnt_q <= prime_cnt_d;
      cfg_ready   <= (state_d == IDLE) || (state_d == PRIME) || (state_d == RUN);
      dec_clr     <= (state_d == IDLE) || (state_d == CLEAR);
      dec_enable  <= (state_d == LOAD);
      dec_prgm    <= prgm_d;
      dec_sig     <= sig_d;
      match       <= match_d;
      match_count <= count_d;
      armed       <= (state_d == RUN);
      underrun    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_decoder256_ctrl.sv
// Directed bench for decoder256_ctrl: load sequencing, priming, qualification,
// underrun, reprogram, saturation and asynchronous reset.
module tb_decoder256_ctrl;

  localparam int unsigned N    = 256;
  localparam int unsigned CNTW = 4;

  logic            clk = 1'b0;
  logic            clr_n, cfg_valid, cfg_ready, sig_in, sig_valid;
  logic            dec_clr, dec_enable, dec_prgm, dec_sig, dec_out;
  logic            match, armed, underrun;
  logic [N-1:0]    cfg_pattern;
  logic [CNTW-1:0] match_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder256_ctrl #(.N(N), .CNTW(CNTW)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .sig_in     (sig_in),
    .sig_valid  (sig_valid),
    .dec_clr    (dec_clr),
    .dec_enable (dec_enable),
    .dec_prgm   (dec_prgm),
    .dec_sig    (dec_sig),
    .dec_out    (dec_out),
    .match      (match),
    .match_count(match_count),
    .armed      (armed),
    .underrun   (underrun)
  );

  typedef struct {
    int         cyc;
    logic       clr;
    logic       en;
    logic       prgm;
    logic       rdy;
    logic       arm;
    logic       mt;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] p1, p2;
  int en_cnt, prgm_err, jj;

  initial begin
    p1 = {{128{1'b1}}, {128{1'b0}}};
    p2 = {128{2'b10}};
    // cycle offset after handshake edge: clr en prgm rdy arm match count
    tbl[0]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{128, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{129, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{256, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[5]  = '{257, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[6]  = '{301, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{512, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{513, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[9]  = '{771, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
    tbl[10] = '{772, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};

    clr_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0;
    sig_in = 1'b0; sig_valid = 1'b0; dec_out = 1'b0;

    // Reset values while clr_n is low
    repeat (3) tick();
    chk("rst_dec_clr", dec_clr, 1);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_dec_enable", dec_enable, 0);
    chk("rst_dec_prgm", dec_prgm, 0);
    chk("rst_dec_sig", dec_sig, 0);
    chk("rst_match", match, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_armed", armed, 0);
    chk("rst_underrun", underrun, 0);
    clr_n = 1'b1;
    tick();
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_dec_clr", dec_clr, 1);

    // Program p1, then stream p1 twice; a cfg_valid during LOAD must be ignored
    cfg_pattern = p1; cfg_valid = 1'b1; sig_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    en_cnt = 0; prgm_err = 0;
    for (int c = 0; c <= 775; c++) begin
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          chk($sformatf("c%0d_dec_clr", c), dec_clr, tbl[i].clr);
          chk($sformatf("c%0d_dec_enable", c), dec_enable, tbl[i].en);
          chk($sformatf("c%0d_dec_prgm", c), dec_prgm, tbl[i].prgm);
          chk($sformatf("c%0d_cfg_ready", c), cfg_ready, tbl[i].rdy);
          chk($sformatf("c%0d_armed", c), armed, tbl[i].arm);
          chk($sformatf("c%0d_match", c), match, tbl[i].mt);
          chk($sformatf("c%0d_match_count", c), match_count, 32'(tbl[i].cnt));
        end
      end
      if (c >= 1 && c <= 256 && dec_prgm !== p1[N - c]) prgm_err++;
      en_cnt += int'(dec_enable);
      if (c == 258) chk("sig_first", dec_sig, 1);
      if (c == 386) chk("sig_mid", dec_sig, 0);
      if (c == 514) chk("sig_copy2", dec_sig, 1);
      cfg_valid   = ((c + 1) == 10);
      cfg_pattern = ((c + 1) == 10) ? '0 : p1;
      jj          = c + 1 - 258;
      sig_in      = (jj >= 0) ? p1[N - 1 - (jj % N)] : 1'b0;
      dec_out     = ((c + 1) == 300) || ((c + 1) == 771);
      tick();
    end
    cfg_valid = 1'b0; dec_out = 1'b0;
    chk("load1_enable_cycles", en_cnt, 256);
    chk("load1_prgm_stream", prgm_err, 0);
    chk("run_no_underrun", underrun, 0);

    // Underrun in RUN drops armed, then a drop at prime count 200 restarts priming
    sig_valid = 1'b0;
    tick();
    chk("run_drop_underrun", underrun, 1);
    chk("run_drop_armed", armed, 0);
    chk("run_drop_match", match, 0);
    sig_valid = 1'b1;
    repeat (200) tick();
    chk("prime200_armed", armed, 0);
    sig_valid = 1'b0;
    tick();
    chk("prime200_drop_underrun", underrun, 1);
    sig_valid = 1'b1;
    repeat (255) tick();
    chk("reprime_armed_early", armed, 0);
    tick();
    chk("reprime_armed", armed, 1);

    // Reprogram from RUN
    chk("pre_reprog_count", match_count, 1);
    chk("pre_reprog_underrun", underrun, 1);
    cfg_pattern = p2; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("reprog_armed", armed, 0);
    chk("reprog_match", match, 0);
    chk("reprog_count", match_count, 0);
    chk("reprog_underrun", underrun, 0);
    chk("reprog_dec_clr", dec_clr, 1);
    chk("reprog_cfg_ready", cfg_ready, 0);
    prgm_err = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (dec_enable !== 1'b1 || dec_clr !== 1'b0 || dec_prgm !== p2[N - 1 - k]) prgm_err++;
    end
    chk("load2_stream", prgm_err, 0);
    tick();
    chk("load2_enable_off", dec_enable, 0);
    chk("load2_ready", cfg_ready, 1);
    repeat (255) tick();
    chk("prime2_armed_early", armed, 0);
    tick();
    chk("prime2_armed", armed, 1);

    // Continuous dec_out saturates the 4-bit counter
    dec_out = 1'b1;
    repeat (15) tick();
    chk("sat_count15", match_count, 15);
    chk("sat_match15", match, 1);
    repeat (5) tick();
    chk("sat_hold", match_count, 15);
    chk("sat_match_hold", match, 1);

    // Asynchronous reset mid-run
    @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    chk("async_armed", armed, 0);
    chk("async_dec_clr", dec_clr, 1);
    chk("async_cfg_ready", cfg_ready, 0);
    chk("async_count", match_count, 0);
    chk("async_match", match, 0);
    dec_out = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_armed", armed, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder256_ctrl.md
# decoder256_ctrl

Sequencer for the 256-bit serial pattern decoder. It accepts a parallel pattern over a valid/ready handshake, clears the decoder, and shifts the pattern in MSB-first with `enable` held high for exactly N cycles. It then streams signal bits into the decoder and qualifies the decoder's `out` only once a full N-bit window of valid signal has been shifted. It replaces ad-hoc stop-counter sequencing and sits directly between the system bus side and the `decoder4`/decoder256 instance.

## Interface
- N, 256, pattern/window length in bits (≥2)
- CNTW, 16, width of match counter
- clk  in  1  clock; all logic on rising edge
- clr_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  new pattern offered
- cfg_ready  out  1  controller can accept pattern (IDLE or RUN/PRIME)
- cfg_pattern  in  N  pattern; bit N-1 is shifted first
- sig_in  in  1  serial signal bit
- sig_valid  in  1  sig_in is valid this cycle
- dec_clr  out  1  active-high clear to decoder
- dec_enable  out  1  decoder program enable
- dec_prgm  out  1  decoder program bit
- dec_sig  out  1  decoder signal bit
- dec_out  in  1  raw decoder match
- match  out  1  qualified match pulse
- match_count  out  CNTW  qualified matches since last pattern load, saturating
- armed  out  1  high in RUN
- underrun  out  1  sticky: sig_valid dropped in PRIME/RUN; cleared on pattern accept

## Operation
- States: IDLE, CLEAR, LOAD, PRIME, RUN.
- All outputs are registered.
- Reset values: state IDLE; dec_clr=1, dec_enable=0, dec_prgm=0, dec_sig=0, match=0, match_count=0, armed=0, underrun=0, cfg_ready=0. During reset and in IDLE, dec_clr stays 1.
- IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) latches cfg_pattern into the shift register, clears match_count and underrun, and moves to CLEAR.
- CLEAR: exactly 1 cycle with dec_clr=1, dec_enable=0. Then LOAD.
- LOAD: N cycles with dec_clr=0, dec_enable=1. In load cycle k (0..N-1), dec_prgm = pattern bit N-1-k. dec_sig=0. cfg_ready=0. After cycle N-1, go to PRIME; dec_enable drops in the same edge.
- PRIME: dec_enable=0, dec_sig = sig_in & sig_valid. The prime counter (width clog2(N)+1) counts consecutive valid cycles. When the count reaches N, go to RUN.
  - A cycle with sig_valid=0 resets the count to 0 and sets underrun. The invalid cycle still shifts 0 into the decoder.
- RUN: armed=1 and dec_sig as in PRIME.
  - match = registered dec_out, gated by armed on the sampling cycle.
  - match_count increments on each match and saturates at 2^CNTW-1.
  - sig_valid=0 sets underrun, drops armed, and returns to PRIME with the count at 0. match is 0 from the next cycle.
- Reprogram: in PRIME or RUN, cfg_ready=1. A handshake aborts streaming (armed=0, match=0), latches the new pattern, clears match_count and underrun, and goes to CLEAR. Reprogram takes priority over an underrun in the same cycle.
- cfg_valid is ignored in CLEAR and LOAD (cfg_ready=0). The pattern is never partially overwritten.

## Timing
- Handshake at edge T. CLEAR in cycle T..T+1. LOAD covers N cycles starting at edge T+1. PRIME begins at edge T+1+N.
- First qualified match is possible on dec_out sampled once N consecutive valid bits have been shifted. match appears 1 cycle after dec_out is sampled.
- Minimum time from handshake to armed: 1+N+N cycles (513 for N=256).
- Mid-operation clr_n assertion returns all state and outputs to their reset values asynchronously. Release is synchronous to the next edge; the block then sits in IDLE.
- Simultaneous match and saturation: count holds at max and the match pulse is still emitted.

## Test plan
- Reset → all outputs at reset values, including dec_clr=1 and cfg_ready=0 while clr_n is low; cfg_ready=1 on the first edge after release.
- Program pattern of 128 ones then 128 zeros → dec_clr is high for 1 cycle, then dec_enable is high for exactly 256 cycles, with dec_prgm=1 for the first 128 and 0 for the last 128. dec_enable=0 on cycle 257.
- After the above, stream the same 256-bit sequence twice with sig_valid=1 → armed rises 256 cycles into PRIME. match pulses once, 1 cycle after dec_out, at the end of the second copy. match_count=1.
- Drop sig_valid for 1 cycle at PRIME count 200 → underrun=1 and the prime counter restarts. armed rises 256 valid cycles later, not 56.
- Assert cfg_valid in LOAD → ignored and pattern unchanged. Assert it in RUN with a new pattern → armed=0 next cycle, match_count=0, underrun=0, and a fresh CLEAR+LOAD of the new pattern follows.
- Force dec_out=1 continuously in RUN with CNTW=4 → match_count saturates at 15 and match stays 1.
